// File: rtl/regfile_pkg.sv
// Shared register-file defaults and the one-hot address decoder used by decoder32 clients.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_ADDR_W = 8;

    // Callers narrow the result to their own 2**ADDR_W entries.
    function automatic logic [(1 << MAX_ADDR_W)-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] addr);
        onehot_dec       = '0;
        onehot_dec[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with flush/issue/write priority and a registered busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_issue,
    output logic [ADDR_W:0]   busy_count
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;
    logic [ADDR_W:0]  cnt_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_en && !(ZR && issue_reg == '0))
            set_mask = DEPTH'(onehot_dec(MAX_ADDR_W'(issue_reg)));
        if (write_en)
            clr_mask = DEPTH'(onehot_dec(MAX_ADDR_W'(write_reg)));
        // Set after clear so a same-cycle issue keeps the new producer pending.
        if (flush)
            busy_next = '0;
        else
            busy_next = (busy & ~clr_mask) | set_mask;
        if (ZR)
            busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= cnt_next;
        end
    end

    assign busy_a     = busy[rd_a]      & ~(BP && write_en && write_reg == rd_a);
    assign busy_b     = busy[rd_b]      & ~(BP && write_en && write_reg == rd_b);
    assign busy_issue = busy[issue_reg] & ~(BP && write_en && write_reg == issue_reg);

endmodule

// File: rtl/regfile_sb.sv
// Register file with two async read ports, one write port, optional bypass/zero register and busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_issueEnable,
    input  logic [ADDR_W-1:0] ctrl_issueReg,
    input  logic              ctrl_flush,
    output logic              busy_readRegA,
    output logic              busy_readRegB,
    output logic              busy_issueReg,
    output logic [ADDR_W:0]   busy_count,
    input  logic [ADDR_W-1:0] ctrl_snoopReg,
    output logic [DATA_W-1:0] data_snoop
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    assign wr_ok = ctrl_writeEnable && !(ZR && ctrl_writeReg == '0);

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[ctrl_writeReg] <= data_writeReg;
        end
    end

    // wr_ok already excludes the zero register, so forwarding never leaks into r0.
    always_comb begin
        data_readRegA = mem[ctrl_readRegA];
        if (BP && wr_ok && ctrl_writeReg == ctrl_readRegA)
            data_readRegA = data_writeReg;
        if (ZR && ctrl_readRegA == '0)
            data_readRegA = '0;
    end

    always_comb begin
        data_readRegB = mem[ctrl_readRegB];
        if (BP && wr_ok && ctrl_writeReg == ctrl_readRegB)
            data_readRegB = data_writeReg;
        if (ZR && ctrl_readRegB == '0)
            data_readRegB = '0;
    end

    always_comb begin
        data_snoop = mem[ctrl_snoopReg];
        if (ZR && ctrl_snoopReg == '0)
            data_snoop = '0;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .write_en   (ctrl_writeEnable),
        .write_reg  (ctrl_writeReg),
        .issue_en   (ctrl_issueEnable),
        .issue_reg  (ctrl_issueReg),
        .flush      (ctrl_flush),
        .rd_a       (ctrl_readRegA),
        .rd_b       (ctrl_readRegB),
        .busy_a     (busy_readRegA),
        .busy_b     (busy_readRegB),
        .busy_issue (busy_issueReg),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA, ctrl_readRegB;
    logic [DW-1:0] data_readRegA, data_readRegB;
    logic          ctrl_issueEnable;
    logic [AW-1:0] ctrl_issueReg;
    logic          ctrl_flush;
    logic          busy_readRegA, busy_readRegB, busy_issueReg;
    logic [AW:0]   busy_count;
    logic [AW-1:0] ctrl_snoopReg;
    logic [DW-1:0] data_snoop;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .ctrl_flush       (ctrl_flush),
        .busy_readRegA    (busy_readRegA),
        .busy_readRegB    (busy_readRegB),
        .busy_issueReg    (busy_issueReg),
        .busy_count       (busy_count),
        .ctrl_snoopReg    (ctrl_snoopReg),
        .data_snoop       (data_snoop)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem  [DEPTH];
    bit            ref_busy [DEPTH];

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input int a);
        if (a == 0) return '0;
        if (ctrl_writeEnable && int'(ctrl_writeReg) == a) return data_writeReg;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (ctrl_writeEnable && int'(ctrl_writeReg) == a) return 1'b0;
        return ref_busy[a];
    endfunction

    function automatic int ref_count();
        int n = 0;
        foreach (ref_busy[i]) n += int'(ref_busy[i]);
        return n;
    endfunction

    task automatic model_edge();
        if (!ctrl_reset) begin
            foreach (ref_mem[i]) begin
                ref_mem[i]  = '0;
                ref_busy[i] = 1'b0;
            end
        end else begin
            if (ctrl_writeEnable && ctrl_writeReg != 0) ref_mem[ctrl_writeReg] = data_writeReg;
            if (ctrl_flush) begin
                foreach (ref_busy[i]) ref_busy[i] = 1'b0;
            end else begin
                if (ctrl_writeEnable) ref_busy[ctrl_writeReg] = 1'b0;
                if (ctrl_issueEnable && ctrl_issueReg != 0) ref_busy[ctrl_issueReg] = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_issueEnable = 1'b0;
        ctrl_issueReg    = '0;
        ctrl_flush       = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        #3;
        check_val("data_readRegA", data_readRegA, exp_read(int'(ctrl_readRegA)));
        check_val("data_readRegB", data_readRegB, exp_read(int'(ctrl_readRegB)));
        check_val("data_snoop", data_snoop, (ctrl_snoopReg == 0) ? '0 : ref_mem[ctrl_snoopReg]);
        check_val("busy_readRegA", DW'(busy_readRegA), DW'(exp_busy(int'(ctrl_readRegA))));
        check_val("busy_readRegB", DW'(busy_readRegB), DW'(exp_busy(int'(ctrl_readRegB))));
        check_val("busy_issueReg", DW'(busy_issueReg), DW'(exp_busy(int'(ctrl_issueReg))));
        @(posedge clock);
        model_edge();
        #1;
        check_val("busy_count", DW'(busy_count), DW'(ref_count()));
    endtask

    initial begin
        idle_inputs();
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        ctrl_snoopReg = '0;
        ctrl_reset    = 1'b0;
        foreach (ref_mem[i]) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
        end
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        check_val("reset_busy_count", DW'(busy_count), '0);

        for (int i = 0; i < DEPTH; i++) begin
            ctrl_readRegA = AW'(i);
            ctrl_readRegB = AW'(DEPTH - 1 - i);
            ctrl_snoopReg = AW'(i);
            cycle();
        end

        // Same-cycle forwarding of a write.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF;
        ctrl_readRegA = 5; ctrl_snoopReg = 5;
        #2 check_val("bypass_r5", data_readRegA, 32'hDEADBEEF);
        check_val("snoop_no_bypass", data_snoop, '0);
        cycle();
        idle_inputs();
        #2 check_val("r5_stored", data_snoop, 32'hDEADBEEF);
        cycle();

        // Issue r7, hold three idle cycles, then retire it.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 7; ctrl_readRegA = 7;
        cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1 check_val("r7_pending", DW'(busy_readRegA), 32'd1);
            cycle();
        end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 7; data_writeReg = 32'h12;
        cycle();
        idle_inputs();
        #1 check_val("r7_retired", DW'(busy_readRegA), 32'd0);
        check_val("r7_count", DW'(busy_count), 32'd0);
        cycle();

        // Issue and write the same register together: new producer stays pending.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 3;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 3; data_writeReg = 32'h55;
        ctrl_readRegA = 3;
        cycle();
        idle_inputs();
        #1 check_val("r3_busy", DW'(busy_readRegA), 32'd1);
        check_val("r3_data", data_readRegA, 32'h55);
        check_val("r3_count", DW'(busy_count), 32'd1);
        cycle();

        // Flush with concurrent write and issue.
        foreach (ref_busy[i]) ref_busy[i] = ref_busy[i];
        for (int r = 1; r <= 4; r++) begin
            if (r == 3) continue;
            ctrl_issueEnable = 1'b1; ctrl_issueReg = AW'(r);
            cycle();
        end
        idle_inputs();
        ctrl_flush = 1'b1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 9; data_writeReg = 32'hA;
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 10;
        cycle();
        idle_inputs();
        ctrl_readRegA = 9; ctrl_readRegB = 10;
        #1 check_val("flush_count", DW'(busy_count), 32'd0);
        check_val("flush_r9", data_readRegA, 32'hA);
        check_val("flush_r10_busy", DW'(busy_readRegB), 32'd0);
        cycle();

        // Zero register: writes and issues have no effect.
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 0; data_writeReg = 32'hFFFFFFFF;
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 0; ctrl_readRegA = 0;
        cycle();
        idle_inputs();
        #1 check_val("r0_data", data_readRegA, '0);
        check_val("r0_busy", DW'(busy_readRegA), '0);
        check_val("r0_count", DW'(busy_count), '0);
        cycle();

        // Reset mid-stream with a pending issue.
        ctrl_issueEnable = 1'b1; ctrl_issueReg = 12;
        cycle();
        idle_inputs();
        ctrl_reset = 1'b0; ctrl_readRegA = 12; ctrl_readRegB = 5;
        cycle();
        idle_inputs();
        #1 check_val("rst_count", DW'(busy_count), '0);
        check_val("rst_r12_busy", DW'(busy_readRegA), '0);
        check_val("rst_r5_data", data_readRegB, '0);
        cycle();

        for (int n = 0; n < 600; n++) begin
            ctrl_reset       = ($urandom_range(0, 59) != 0);
            ctrl_flush       = ($urandom_range(0, 19) == 0);
            ctrl_writeEnable = ($urandom_range(0, 1) == 1);
            ctrl_issueEnable = ($urandom_range(0, 2) != 0);
            ctrl_writeReg    = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7));
            ctrl_issueReg    = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7));
            ctrl_readRegA    = AW'($urandom_range(0, 7));
            ctrl_readRegB    = AW'($urandom_range(0, 1) == 0 ? ctrl_writeReg : AW'($urandom_range(0, DEPTH - 1)));
            ctrl_snoopReg    = AW'($urandom_range(0, 7));
            data_writeReg    = DW'($urandom());
            cycle();
        end

        idle_inputs();
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the processor's 32x32 register file. It provides a DEPTH x DATA_W storage array with two asynchronous read ports and one synchronous write port. Optional write-to-read bypass and an optional hardwired zero register are selected by parameter. An integrated per-register scoreboard (busy bits plus a busy counter) lets the pipeline stall on RAW/WAW hazards. The block sits in decode: read addresses come from the fetched instruction, writeback drives the write port, and issue marks destinations pending.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes, never goes busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports and busy outputs
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  synchronous, active-low reset
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_W  write address
- data_writeReg  in  DATA_W  write data
- ctrl_readRegA, ctrl_readRegB  in  ADDR_W  read addresses
- data_readRegA, data_readRegB  out  DATA_W  read data (combinational)
- ctrl_issueEnable  in  1  mark ctrl_issueReg pending
- ctrl_issueReg  in  ADDR_W  destination being issued
- ctrl_flush  in  1  clear all busy bits; data untouched
- busy_readRegA, busy_readRegB  out  1  pending status of read addresses
- busy_issueReg  out  1  pending status of ctrl_issueReg (WAW check)
- busy_count  out  ADDR_W+1  number of busy entries (registered)
- ctrl_snoopReg  in  ADDR_W  debug/IO snoop address
- data_snoop  out  DATA_W  array contents at ctrl_snoopReg, no bypass

## Operation
- Priority at each edge: reset > flush > issue-set > write-clear.
- ctrl_reset low: all entries 0, all busy bits 0, busy_count 0. All other inputs are ignored that cycle.
- Write: when ctrl_writeEnable is 1, entry[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0. A write to entry 0 is dropped when ZERO_REG=1.
- Issue: when ctrl_issueEnable is 1, busy[ctrl_issueReg] <= 1. Issue to entry 0 is ignored when ZERO_REG=1. Re-issuing a register that is already busy is legal; the bit stays at 1.
- Issue and write to the same register in the same cycle: busy ends at 1 (new producer wins) and the data is written.
- Flush: all busy bits go to 0, but a write in the same cycle still updates data. An issue in the same cycle is discarded.
- Read data: entry[addr]. With BYPASS=1, when ctrl_writeEnable is 1 and ctrl_writeReg == addr (and addr is not the zero register), the read returns data_writeReg.
- Busy read: busy[addr]. With BYPASS=1 it is forced to 0 when a same-cycle write targets addr. busy_issueReg follows the same rule.
- busy_count always equals the popcount of the busy bits after the edge. Its range is 0..DEPTH (DEPTH-1 when ZERO_REG=1), and it cannot wrap.
- Reads of the zero register (ZERO_REG=1) always return 0 and not-busy, including from data_snoop.

## Timing
- Write latency 1: data is visible via the array the cycle after the edge. With BYPASS=1 it is visible combinationally in the same cycle.
- Issue latency 1: busy is visible the cycle after ctrl_issueEnable.
- Flush latency 1: busy bits and busy_count read 0 the cycle after.
- Reset recovery: the first cycle with ctrl_reset high is fully operational, and reads return 0.
- Read ports and busy outputs are purely combinational from addresses plus state. busy_count is a flop output.

## Structure
- Package regfile_pkg holds the DATA_W and ADDR_W defaults and a function for a one-hot ADDR_W-to-DEPTH decoder, shared with the decoder32 users.
- Sub-module regfile_scoreboard holds the busy bits, priority logic and busy_count. The top level holds the data array, bypass muxes and snoop mux.

## Test plan
- Reset, then read all addresses on A, B and snoop -> all 0; busy_count = 0.
- Write 0xDEADBEEF to r5, reading r5 on A in the same cycle: BYPASS=1 -> A = 0xDEADBEEF that cycle; BYPASS=0 -> old value 0, then 0xDEADBEEF the next cycle.
- Issue r7, then 3 idle cycles, then write r7 = 0x12 -> busy_readRegA(r7) = 1 for 3 cycles, then 0; busy_count goes 1 -> 0.
- Issue r3 and write r3 = 0x55 in the same cycle -> next cycle busy(r3) = 1, A(r3) = 0x55, busy_count = 1.
- Issue r1, r2, r4, then flush together with a write of r9 = 0xA and an issue of r10 -> busy_count = 0, r9 = 0xA, r10 not busy.
- ZERO_REG=1: write r0 = 0xFFFFFFFF and issue r0 -> r0 reads 0, not busy, busy_count unchanged. Then assert ctrl_reset low mid-stream with a pending issue -> everything reads 0 the next cycle.
